alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one registered signed ALU (ctrl 00 mul, 01 append, 11 plus, 10 default) between two requesters.
- Each requester hands over one op with a valid/ready handshake. The block drives the ALU operand and ctrl ports and waits the ALU latency.
- It returns the result on a response channel that carries the requester id.
- Sits between requester FSMs and the shared ALU instance.

Parameters:
- WIDTH, 8, operand width; result width is 2*WIDTH.
- ALU_LAT, 1, edges between ALU inputs being stable and alu_out being valid (≥1).

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  asynchronous active-low reset; rst=0 clears all state immediately.
- r0_valid  input  1  requester 0 has an op.
- r0_ready  output  1  requester 0 op accepted this cycle.
- r0_ctrl  input  2  requester 0 ALU function.
- r0_a  input  WIDTH  requester 0 operand A (signed).
- r0_b  input  WIDTH  requester 0 operand B (signed).
- r1_valid, r1_ready, r1_ctrl, r1_a, r1_b: same widths and meanings, for requester 1.
- alu_ctrl  output  2  ALU function select.
- alu_a  output  WIDTH  ALU operand A.
- alu_b  output  WIDTH  ALU operand B.
- alu_out  input  2*WIDTH  ALU registered result.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer takes result.
- resp_id  output  1  requester that issued the result.
- resp_data  output  2*WIDTH  result.
- busy  output  1  high when state != IDLE.

Behaviour:
- Reset (rst=0, async): state IDLE, rr pointer=0 (requester 0 favoured), lat counter=0. alu_ctrl, alu_a, alu_b, resp_data, resp_id, resp_valid, busy all 0. r0_ready=r1_ready=0 while rst=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational: only one valid → that requester; both valid → the requester named by the rr pointer.
  - rN_ready=1 only in IDLE and only for the granted N.
  - On valid&&ready at a posedge: register rN_ctrl/a/b into alu_ctrl/a/b, latch id, set pointer to the other requester, clear counter, go EXEC.
  - No valid → stay IDLE; pointer unchanged.
- EXEC:
  - alu_* held stable. Counter increments each posedge.
  - When counter==ALU_LAT, alu_out is captured into resp_data and resp_id is set from the latched id at that posedge; state goes RESP.
  - With ALU_LAT=1, resp_valid rises 2 posedges after the accept edge.
- RESP:
  - resp_valid=1; resp_data and resp_id stable until resp_valid&&resp_ready at a posedge. Then resp_valid=0 and state goes IDLE.
  - No new accept in that same cycle. Max rate is one op per ALU_LAT+3 cycles (4 for ALU_LAT=1).
- After an op, alu_* keep their last values; they are not zeroed.
- All four ctrl codes pass through unchanged; the block does not interpret ctrl.
- A requester may drop valid before ready; this has no side effects. Inputs are sampled only on the handshake edge.
- Any requester inputs changing outside IDLE are ignored.
- Reset mid-op (EXEC or RESP): the in-flight op is discarded, no resp_valid, pointer returns to 0.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined: output ports gnt_cnt0 and gnt_cnt1, each 8 bits. Each counts accepted handshakes of its requester, saturates at 255, and is cleared only by rst.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: rst=0 asserted between clock edges during EXEC → all outputs 0 immediately. After release, first simultaneous request is granted to r0.
- Single op: r0 ctrl=00, a=-3, b=5, resp_ready=1 → r0_ready=1 in the same cycle; resp_valid 2 edges later with resp_data=16'hFFF1, resp_id=0; busy high for 3 cycles.
- Append via r1: ctrl=01, a=8'h17, b=8'hd3 → resp_data=16'h17d3, resp_id=1; alu_a/alu_b stay 17/d3 afterwards.
- Contention: r0 and r1 valid continuously, resp_ready=1 → grant order 0,1,0,1,…; one response every 4 cycles; neither requester is granted twice in a row.
- Backpressure: resp_ready=0 for 5 cycles in RESP → resp_valid/resp_data/resp_id stable, r0_ready=r1_ready=0, busy=1. resp_ready=1 → IDLE next cycle.
- ARB_STATS_EN: 300 r1-only ops → gnt_cnt1=255, gnt_cnt0=0; rst=0 → both 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered ALU between two requesters.
// Optional grant statistics counters (gnt_cnt0/gnt_cnt1) are enabled with `define ARB_STATS_EN.
module alu_share_arbiter #(
    parameter int WIDTH   = 8,
    parameter int ALU_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               r0_valid,
    output logic               r0_ready,
    input  logic [1:0]         r0_ctrl,
    input  logic [WIDTH-1:0]   r0_a,
    input  logic [WIDTH-1:0]   r0_b,
    input  logic               r1_valid,
    output logic               r1_ready,
    input  logic [1:0]         r1_ctrl,
    input  logic [WIDTH-1:0]   r1_a,
    input  logic [WIDTH-1:0]   r1_b,
    output logic [1:0]         alu_ctrl,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    input  logic [2*WIDTH-1:0] alu_out,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp_id,
    output logic [2*WIDTH-1:0] resp_data,
`ifdef ARB_STATS_EN
    output logic [7:0]         gnt_cnt0,
    output logic [7:0]         gnt_cnt1,
`endif
    output logic               busy
);

    localparam int CW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic          rr;
    logic          id_q;
    logic [CW-1:0] cnt;
    logic          gnt_any, gnt_id, accept, exec_done, resp_done;

    // Grant is purely combinational; rr only breaks ties when both are valid.
    always_comb begin
        gnt_any   = r0_valid | r1_valid;
        gnt_id    = (r0_valid && r1_valid) ? rr : r1_valid;
        accept    = (state == IDLE) && gnt_any;
        exec_done = (state == EXEC) && (cnt == CW'(ALU_LAT));
        resp_done = (state == RESP) && resp_ready;
        state_nx  = state;
        case (state)
            IDLE:    if (accept)    state_nx = EXEC;
            EXEC:    if (exec_done) state_nx = RESP;
            RESP:    if (resp_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Ready is gated by rst so nothing looks accepted while reset is held.
    assign r0_ready   = rst && accept && !gnt_id;
    assign r1_ready   = rst && accept &&  gnt_id;
    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr        <= 1'b0;
            id_q      <= 1'b0;
            cnt       <= '0;
            alu_ctrl  <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            resp_data <= '0;
            resp_id   <= 1'b0;
        end else if (accept) begin
            alu_ctrl <= gnt_id ? r1_ctrl : r0_ctrl;
            alu_a    <= gnt_id ? r1_a    : r0_a;
            alu_b    <= gnt_id ? r1_b    : r0_b;
            id_q     <= gnt_id;
            rr       <= ~gnt_id;
            cnt      <= '0;
        end else if (state == EXEC) begin
            // alu_* stay untouched here so the ALU sees stable operands.
            cnt <= cnt + 1'b1;
            if (exec_done) begin
                resp_data <= alu_out;
                resp_id   <= id_q;
            end
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else if (accept) begin
            if (!gnt_id && gnt_cnt0 != 8'hFF) gnt_cnt0 <= gnt_cnt0 + 8'd1;
            if ( gnt_id && gnt_cnt1 != 8'hFF) gnt_cnt1 <= gnt_cnt1 + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural registered ALU (latency 1).
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        r0_valid = 0, r1_valid = 0;
    logic        r0_ready, r1_ready;
    logic [1:0]  r0_ctrl = 0, r1_ctrl = 0;
    logic [7:0]  r0_a = 0, r0_b = 0, r1_a = 0, r1_b = 0;
    logic [1:0]  alu_ctrl;
    logic [7:0]  alu_a, alu_b;
    logic [15:0] alu_out = 16'h0;
    logic        resp_valid, resp_ready = 0, resp_id;
    logic [15:0] resp_data;
    logic        busy;
`ifdef ARB_STATS_EN
    logic [7:0]  gnt_cnt0, gnt_cnt1;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(8), .ALU_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_ctrl(r0_ctrl), .r0_a(r0_a), .r0_b(r0_b),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_ctrl(r1_ctrl), .r1_a(r1_a), .r1_b(r1_b),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data),
`ifdef ARB_STATS_EN
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1),
`endif
        .busy(busy)
    );

    function automatic logic [15:0] alu_f(input logic [1:0] c, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] ea, eb;
        ea = {{8{a[7]}}, a};
        eb = {{8{b[7]}}, b};
        case (c)
            2'b00:   return ea * eb;
            2'b01:   return {a, b};
            2'b11:   return ea + eb;
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge clk) alu_out <= alu_f(alu_ctrl, alu_a, alu_b);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic        id;
        logic [1:0]  ctrl;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    task automatic do_op(input vec_t v);
        @(negedge clk);
        resp_ready = 1;
        if (v.id) begin
            r1_valid = 1; r1_ctrl = v.ctrl; r1_a = v.a; r1_b = v.b;
        end else begin
            r0_valid = 1; r0_ctrl = v.ctrl; r0_a = v.a; r0_b = v.b;
        end
        #1;
        chk("ready_granted", v.id ? r1_ready : r0_ready, 1);
        chk("ready_other",   v.id ? r0_ready : r1_ready, 0);
        @(negedge clk);
        r0_valid = 0; r1_valid = 0; r0_a = 8'h55; r1_a = 8'h55;
        #1;
        chk("exec1_busy", busy, 1);
        chk("exec1_rv", resp_valid, 0);
        chk("alu_ctrl", alu_ctrl, v.ctrl);
        chk("alu_a", alu_a, v.a);
        chk("alu_b", alu_b, v.b);
        @(negedge clk); #1;
        chk("exec2_busy", busy, 1);
        chk("exec2_rv", resp_valid, 0);
        @(negedge clk); #1;
        chk("resp_valid", resp_valid, 1);
        chk("resp_data", resp_data, v.exp);
        chk("resp_id", resp_id, v.id);
        chk("resp_busy", busy, 1);
        @(negedge clk); #1;
        chk("idle_rv", resp_valid, 0);
        chk("idle_busy", busy, 0);
        chk("alu_a_kept", alu_a, v.a);
        chk("alu_b_kept", alu_b, v.b);
    endtask

    initial begin
        vec_t vt[6];
        int   last, exp_id, grants;
        logic found;
        vt[0] = '{1'b0, 2'b00, 8'hFD, 8'h05, 16'hFFF1};
        vt[1] = '{1'b1, 2'b01, 8'h17, 8'hD3, 16'h17D3};
        vt[2] = '{1'b0, 2'b11, 8'h7F, 8'h01, 16'h0080};
        vt[3] = '{1'b1, 2'b11, 8'h80, 8'h80, 16'hFF00};
        vt[4] = '{1'b0, 2'b00, 8'h80, 8'h80, 16'h4000};
        vt[5] = '{1'b1, 2'b10, 8'h12, 8'h34, 16'h0000};

        // Reset state, with a request pending to show ready stays low.
        r0_valid = 1;
        #3;
        chk("rst_r0_ready", r0_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_alu", {alu_ctrl, alu_a, alu_b}, 0);
        chk("rst_resp", {resp_id, resp_data}, 0);
        @(negedge clk);
        rst = 1; r0_valid = 0;

        for (int i = 0; i < 6; i++) do_op(vt[i]);

        // Reset during EXEC: r0 accepted alone (rr -> 1), then reset must clear rr.
        @(negedge clk);
        r0_valid = 1; r0_ctrl = 2'b00; r0_a = 8'd2; r0_b = 8'd3;
        r1_ctrl = 2'b01; r1_a = 8'h01; r1_b = 8'h02;
        resp_ready = 1;
        @(negedge clk);
        r1_valid = 1;
        chk("pre_rst_busy", busy, 1);
        #2 rst = 0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_rv", resp_valid, 0);
        chk("midrst_alu", {alu_ctrl, alu_a, alu_b}, 0);
        chk("midrst_resp", {resp_id, resp_data}, 0);
        chk("midrst_ready", {r0_ready, r1_ready}, 0);
        @(negedge clk);
        chk("midrst_rv2", resp_valid, 0);
        rst = 1;

        // Contention: both valid continuously; expect 0,1,0,1... every 4 cycles.
        last = -1; exp_id = 0; grants = 0;
        for (int c = 0; c < 26; c++) begin
            #1;
            if (r0_ready | r1_ready) begin
                grants++;
                chk("cont_grant", {r0_ready, r1_ready}, exp_id ? 2'b01 : 2'b10);
                if (last >= 0) chk("cont_gap", c - last, 4);
                last = c;
                exp_id ^= 1;
            end
            if (resp_valid) chk("cont_data", resp_data, resp_id ? 16'h0102 : 16'h0006);
            @(negedge clk);
        end
        chk("cont_grants", grants, 7);
        r0_valid = 0; r1_valid = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!busy) break;
            @(negedge clk);
        end
        chk("drain", busy, 0);

        // Backpressure: held response, late inputs ignored.
        @(negedge clk);
        resp_ready = 0;
        r0_valid = 1; r0_ctrl = 2'b00; r0_a = 8'hFE; r0_b = 8'h07;
        @(negedge clk);
        r1_valid = 1; r0_a = 8'h11;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (resp_valid) begin found = 1; break; end
        end
        chk("bp_resp_seen", found, 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rv", resp_valid, 1);
            chk("bp_data", resp_data, 16'hFFF2);
            chk("bp_id", resp_id, 0);
            chk("bp_ready", {r0_ready, r1_ready}, 0);
            chk("bp_busy", busy, 1);
            @(negedge clk); #1;
        end
        resp_ready = 1; r0_valid = 0; r1_valid = 0;
        @(negedge clk); #1;
        chk("bp_release_rv", resp_valid, 0);
        chk("bp_release_busy", busy, 0);
        chk("bp_alu_a", alu_a, 8'hFE);

`ifdef ARB_STATS_EN
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        rst = 1;
        r1_valid = 1; r1_ctrl = 2'b01; resp_ready = 1;
        for (int i = 0; i < 1210; i++) @(negedge clk);
        r1_valid = 0;
        for (int i = 0; i < 6; i++) @(negedge clk);
        #1;
        chk("stats_cnt1_sat", gnt_cnt1, 8'd255);
        chk("stats_cnt0", gnt_cnt0, 8'd0);
        rst = 0;
        #1;
        chk("stats_rst", {gnt_cnt0, gnt_cnt1}, 0);
        @(negedge clk);
        rst = 1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
